// File: rtl/glitch_filter_if.sv
// glitch_filter_if: channel inputs, sample enable and filtered outputs of glitch_filter
interface glitch_filter_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             en;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             changed;
   modport master (output din, en, input dout, rise, fall, changed);
   modport slave (input din, en, output dout, rise, fall, changed);
endinterface

// File: rtl/glitch_filter.sv
// glitch_filter: per-channel synchroniser plus STABLE-enabled-cycle persistence filter with edge pulses
module glitch_filter #(
   parameter int   WIDTH   = 4,
   parameter int   STABLE  = 3,
   parameter int   SYNC    = 2,
   parameter logic RST_VAL = 1'b0
) (
   input logic            clk,
   input logic            rst,
   glitch_filter_if.slave bus
);
   localparam int CW = $clog2(STABLE + 1);
   typedef enum logic {IDLE, PEND} state_t;
   logic [WIDTH-1:0] s, dout, dout_n, rise, rise_n, fall, fall_n;
   logic             changed;
   state_t           state [WIDTH];
   state_t           state_n [WIDTH];
   logic [CW-1:0]    cnt [WIDTH];
   logic [CW-1:0]    cnt_n [WIDTH];
   generate
      if (SYNC == 0) begin : g_nosync
         assign s = bus.din;
      end else begin : g_sync
         logic [WIDTH-1:0] chain [SYNC];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < SYNC; k++) chain[k] <= {WIDTH{RST_VAL}};
            end else begin
               chain[0] <= bus.din;
               for (int k = 1; k < SYNC; k++) chain[k] <= chain[k-1];
            end
         end
         assign s = chain[SYNC-1];
      end
   endgenerate
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         state_n[i] = state[i];
         cnt_n[i]   = cnt[i];
         dout_n[i]  = dout[i];
         rise_n[i]  = 1'b0;
         fall_n[i]  = 1'b0;
         if (bus.en && s[i] != dout[i]) begin
            // STABLE==1 accepts on the first differing sample, never entering PEND
            if (STABLE == 1 || (state[i] == PEND && cnt[i] == CW'(STABLE - 1))) begin
               dout_n[i]  = s[i];
               rise_n[i]  = s[i];
               fall_n[i]  = !s[i];
               state_n[i] = IDLE;
               cnt_n[i]   = '0;
            end else begin
               state_n[i] = PEND;
               cnt_n[i]   = state[i] == IDLE ? CW'(1) : cnt[i] + CW'(1);
            end
         end else if (bus.en) begin
            state_n[i] = IDLE;
            cnt_n[i]   = '0;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout    <= {WIDTH{RST_VAL}};
         rise    <= '0;
         fall    <= '0;
         changed <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         dout    <= dout_n;
         rise    <= rise_n;
         fall    <= fall_n;
         changed <= |(rise_n | fall_n);
         for (int i = 0; i < WIDTH; i++) begin
            state[i] <= state_n[i];
            cnt[i]   <= cnt_n[i];
         end
      end
   end
   assign bus.dout    = dout;
   assign bus.rise    = rise;
   assign bus.fall    = fall;
   assign bus.changed = changed;
endmodule
